// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the raw pins, deframes
// 11-bit device-to-host frames and folds E0/F0 prefixes into per-code flags.
module ps2_scancode_rx #(
  parameter int clk_mhz    = 25,
  parameter int timeout_us = 100,
  parameter int filter_len = 8
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       code_release,
  output logic       code_extended,
  output logic       frame_err,
  output logic       busy
);

  localparam int TIMEOUT_CYC = clk_mhz * timeout_us;
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
  // fall is registered, so the counter restarts one cycle late; firing at
  // TIMEOUT_CYC-2 puts frame_err exactly TIMEOUT_CYC cycles after fall.
  localparam logic [CNT_W-1:0] TIMEOUT_HIT = CNT_W'(TIMEOUT_CYC - 2);

  localparam logic [7:0] BYTE_RELEASE  = 8'hF0;
  localparam logic [7:0] BYTE_EXTENDED = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic                  clk_meta_reg, clk_sync_reg;
  logic                  data_meta_reg, data_sync_reg;
  logic [filter_len-1:0] hist_reg;
  logic                  filt_reg, filt_prev_reg, fall_reg;

  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt_reg;
  logic             par_ok_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             pend_rel_reg, pend_ext_reg;

  logic byte_done, err_now, timeout_hit;

  // Two-flop synchronizers; lines idle high.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      clk_meta_reg  <= 1'b1;
      clk_sync_reg  <= 1'b1;
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      clk_meta_reg  <= ps2clk;
      clk_sync_reg  <= clk_meta_reg;
      data_meta_reg <= ps2data;
      data_sync_reg <= data_meta_reg;
    end
  end

  // Clock de-glitch: level only changes on a full run of identical samples.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hist_reg      <= '1;
      filt_reg      <= 1'b1;
      filt_prev_reg <= 1'b1;
      fall_reg      <= 1'b0;
    end else begin
      hist_reg <= {hist_reg[filter_len-2:0], clk_sync_reg};
      if (hist_reg == '0) begin
        filt_reg <= 1'b0;
      end else if (&hist_reg) begin
        filt_reg <= 1'b1;
      end
      filt_prev_reg <= filt_reg;
      fall_reg      <= filt_prev_reg & ~filt_reg;
    end
  end

  assign timeout_hit = (state_reg != IDLE) && !fall_reg && (tmo_cnt_reg == TIMEOUT_HIT);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    byte_done  = 1'b0;
    err_now    = 1'b0;
    if (timeout_hit) begin
      state_next = IDLE;
      err_now    = 1'b1;
    end else if (fall_reg) begin
      case (state_reg)
        IDLE: begin
          if (!data_sync_reg) begin
            state_next = DATA;
          end
        end
        DATA: begin
          if (bit_cnt_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
        PARITY: begin
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (data_sync_reg && par_ok_reg) begin
            byte_done = 1'b1;
          end else begin
            err_now = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Shift register, bit counter and parity check.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      shift_reg   <= 8'h00;
      bit_cnt_reg <= 3'd0;
      par_ok_reg  <= 1'b0;
    end else if (fall_reg && !timeout_hit) begin
      case (state_reg)
        IDLE: begin
          if (!data_sync_reg) begin
            bit_cnt_reg <= 3'd0;
          end
        end
        DATA: begin
          shift_reg   <= {data_sync_reg, shift_reg[7:1]};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
        PARITY: begin
          par_ok_reg <= (^shift_reg) ^ data_sync_reg;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tmo_cnt_reg <= '0;
    end else if (fall_reg || state_reg == IDLE) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end

  // Prefix folding and output delivery.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      code          <= 8'h00;
      code_valid    <= 1'b0;
      code_release  <= 1'b0;
      code_extended <= 1'b0;
      frame_err     <= 1'b0;
      pend_rel_reg  <= 1'b0;
      pend_ext_reg  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= err_now;
      if (err_now) begin
        pend_rel_reg <= 1'b0;
        pend_ext_reg <= 1'b0;
      end else if (byte_done) begin
        if (shift_reg == BYTE_RELEASE) begin
          pend_rel_reg <= 1'b1;
        end else if (shift_reg == BYTE_EXTENDED) begin
          pend_ext_reg <= 1'b1;
        end else begin
          code          <= shift_reg;
          code_release  <= pend_rel_reg;
          code_extended <= pend_ext_reg;
          code_valid    <= 1'b1;
          pend_rel_reg  <= 1'b0;
          pend_ext_reg  <= 1'b0;
        end
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receiver that sits directly upstream of the UK101 keyboard matrix emulation. It synchronizes and de-glitches the raw `ps2clk`/`ps2data` pins and deframes 11-bit device-to-host frames. It folds the `E0` (extended) and `F0` (release) prefixes into flags and delivers one qualified scancode per key event as a single-cycle strobe. It is receive-only; the host never drives the PS/2 lines.

## Interface
Parameters:
- `clk_mhz`, default 25: system clock frequency in MHz.
- `timeout_us`, default 100: maximum gap between PS/2 clock falling edges inside a frame. Timeout cycles = `clk_mhz*timeout_us`, default 2500.
- `filter_len`, default 8: number of consecutive identical samples required to change the filtered `ps2clk` level. Range 2..16.

Ports:
- `clk` in 1: system clock; the block uses this single clock only.
- `n_reset` in 1: reset, asynchronous, active-low.
- `ps2clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2data` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `code` out 8: last delivered scancode; held until the next delivery.
- `code_valid` out 1: one-cycle strobe when `code`/`code_release`/`code_extended` are updated.
- `code_release` out 1: the delivered code was preceded by `F0`.
- `code_extended` out 1: the delivered code was preceded by `E0`.
- `frame_err` out 1: one-cycle strobe on a parity, stop-bit or timeout error.
- `busy` out 1: high while a frame is in progress, i.e. state is not IDLE.

## Operation
- **Synchronizer:** two flops on each pin. Reset value is 1 for both pins.
- **Filter:** filtered clock goes 0 when the last `filter_len` synchronized samples are all 0, and goes 1 when they are all 1. Otherwise it holds. Reset value is 1.
- **Edge detect:** `fall` is registered. It is high for one cycle when the filtered clock transitions 1→0. Data is sampled from the synchronized `ps2data` on that cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP. Every transition happens only on `fall`, except timeout.
  - IDLE: if sampled data is 0 (start bit), clear the bit counter and go to DATA. If it is 1, stay in IDLE and raise no error.
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: compute the XOR of the 8 data bits and the parity bit. Latch `par_ok` = (result == 1), which is odd parity. Go to STOP.
  - STOP: if the stop bit is 1 and `par_ok`, process the byte; otherwise pulse `frame_err`. Go to IDLE in either case.
- **Timeout:** the counter clears on every `fall` and counts while the state is not IDLE. When it reaches timeout cycles, go to IDLE, pulse `frame_err`, and discard the partial byte.
- **Byte processing** (cycle after the STOP `fall`):
  - `F0`: set the pending release flag; no output.
  - `E0`: set the pending extended flag; no output.
  - Any other byte: load `code`, copy both pending flags to `code_release`/`code_extended`, pulse `code_valid`, then clear both pending flags.
  - `E0 F0 xx` therefore yields `xx` with release=1 and extended=1.
- **Any `frame_err`** also clears both pending flags.
- **Reset values:** `code`=0x00, `code_valid`=0, `code_release`=0, `code_extended`=0, `frame_err`=0, `busy`=0. State is IDLE, pending flags are 0, timeout counter is 0.
- **Reset mid-frame:** all state returns immediately to the reset values. A later clean frame must decode correctly.

## Timing
- Raw-pin latency: raw `ps2clk` is first sampled low at clk edge 0, with all later samples also low. The filtered clock becomes 0 at edge `2+filter_len`. `fall` is high at `3+filter_len`.
- `code_valid`/`frame_err` assert in the cycle after the stop-bit `fall`. With defaults that is edge 12 relative to the stop-bit raw fall.
- Timeout `frame_err` pulses exactly `clk_mhz*timeout_us` cycles after the last `fall`, or after entry to DATA.
- `code_valid` and `frame_err` are never high in the same cycle. Each is exactly one cycle wide.
- `busy` rises in the cycle after the start-bit `fall` and falls in the cycle after the stop-bit `fall` or the timeout.
- Glitches on `ps2clk` shorter than `filter_len` cycles produce no `fall`.
- The minimum supported PS/2 half-period is `filter_len+4` clk cycles. Real devices run at 30–50 µs, well above this.

## Test plan
- Frame `1C` (start 0, data LSB-first, parity 0, stop 1), bit period 2000 cycles → `code_valid` once with `code`=0x1C, release=0, extended=0, `frame_err` stays 0.
- Frames `F0`,`1C` → exactly one `code_valid`, with `code`=0x1C and release=1. `code_valid` does not fire for `F0`.
- Frames `E0`,`F0`,`75` → one `code_valid` with `code`=0x75, release=1, extended=1. A following `1C` gives release=0, extended=0.
- Frame `1C` with the parity bit flipped → `frame_err` pulses once and `code_valid` stays 0. Frame `F0` with a bad stop bit, then `1C` → error, then `1C` with release=0.
- Stop `ps2clk` after 4 data bits → `frame_err` exactly 2500 cycles after the last fall and `busy`→0. A subsequent clean `29` frame decodes to 0x29.
- 3-cycle low glitches on `ps2clk` while idle → no state change. Assert `n_reset` mid-frame → all outputs 0 immediately, and the next clean frame decodes.
